// File: rtl/adsr_envelope_if.sv
// Envelope control/status bundle between the sequencer and one envelope voice.
// Latency: none (wires only).
// Backpressure: none; the envelope samples controls every clock and advances on env_tick.
//
// Signals:
//   env_tick       shared envelope tick strobe
//   gate           note on/off, level-sensitive
//   attack_rate    ticks per attack step, minus 1
//   decay_rate     ticks per decay step, minus 1
//   sustain_level  sustain volume 0..63
//   release_rate   ticks per release step, minus 1
//   vol            envelope level to the oscillator
//   env_active     high whenever the envelope is not IDLE
//   stage          0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
interface adsr_envelope_if #(
    parameter int RATE_WIDTH = 8
);
    logic                  env_tick;
    logic                  gate;
    logic [RATE_WIDTH-1:0] attack_rate;
    logic [RATE_WIDTH-1:0] decay_rate;
    logic [5:0]            sustain_level;
    logic [RATE_WIDTH-1:0] release_rate;
    logic [5:0]            vol;
    logic                  env_active;
    logic [2:0]            stage;

    // Sequencer side.
    modport master (
        output env_tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        input  vol, env_active, stage
    );

    // Envelope side.
    modport slave (
        input  env_tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        output vol, env_active, stage
    );
endinterface

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator producing the 6-bit oscillator volume word.
// Latency: a step taken on a tick at cycle N shows on vol at N+1; stage and env_active update with the state.
// Backpressure: none; the level moves only on env_tick, and the gate is sampled every clock.
//
// Ports:
//   clk             system clock
//   rst_active_low  asynchronous active-low reset
//   bus             adsr_envelope_if.slave (controls in, vol/env_active/stage out)
//
// Build option: define ADSR_RETRIG_EN so that a gate rise from any state clears the level
// and restarts ATTACK. Left undefined, retrigger is legato: ATTACK starts from the current
// level, and a rise is honoured only from IDLE or RELEASE.
module adsr_envelope #(
    parameter int RATE_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_active_low,
    adsr_envelope_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [5:0] LEVEL_MAX = 6'd63;

    state_t                state_q, state_d;
    logic [5:0]            level_q, level_d;
    logic [RATE_WIDTH-1:0] rate_cnt_q, rate_cnt_d;
    logic                  gate_q;
    logic [2:0]            stage_q;
    logic                  env_active_q;

    logic rise;
    logic fall;
    logic trig_ok;
    logic step_now;

    assign rise = bus.gate & ~gate_q;
    assign fall = ~bus.gate & gate_q;

`ifdef ADSR_RETRIG_EN
    // Any rise restarts the note, even if the preceding fall was missed.
    assign trig_ok = 1'b1;
`else
    // Legato: a rise only matters when the note is not already held.
    assign trig_ok = (state_q == S_IDLE) || (state_q == S_RELEASE);
`endif

    // The rate counter has run out on a tick, so a level step is due this cycle.
    assign step_now = bus.env_tick && (rate_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        rate_cnt_d = rate_cnt_q;

        if (rise && trig_ok) begin
            state_d    = S_ATTACK;
            rate_cnt_d = bus.attack_rate;
`ifdef ADSR_RETRIG_EN
            level_d    = '0;
`endif
        end else if (fall && (state_q == S_ATTACK || state_q == S_DECAY ||
                              state_q == S_SUSTAIN)) begin
            // Any step that would have happened this cycle is dropped.
            state_d    = S_RELEASE;
            rate_cnt_d = bus.release_rate;
        end else begin
            case (state_q)
                S_ATTACK: begin
                    if (level_q == LEVEL_MAX) begin
                        state_d    = S_DECAY;
                        rate_cnt_d = bus.decay_rate;
                    end else if (bus.env_tick) begin
                        if (step_now) begin
                            level_d    = level_q + 6'd1;
                            rate_cnt_d = bus.attack_rate;
                        end else begin
                            rate_cnt_d = rate_cnt_q - RATE_WIDTH'(1);
                        end
                    end
                end
                S_DECAY: begin
                    // Checked every clock, so a sustain at or above the level exits at once.
                    if (level_q <= bus.sustain_level) begin
                        state_d    = S_SUSTAIN;
                        rate_cnt_d = '0;
                    end else if (bus.env_tick) begin
                        if (step_now) begin
                            level_d    = level_q - 6'd1;
                            rate_cnt_d = bus.decay_rate;
                        end else begin
                            rate_cnt_d = rate_cnt_q - RATE_WIDTH'(1);
                        end
                    end
                end
                S_SUSTAIN: begin
                    // Follows live sustain edits one clock later.
                    level_d = bus.sustain_level;
                end
                S_RELEASE: begin
                    if (level_q == '0) begin
                        state_d    = S_IDLE;
                        rate_cnt_d = '0;
                    end else if (bus.env_tick) begin
                        if (step_now) begin
                            level_d    = level_q - 6'd1;
                            rate_cnt_d = bus.release_rate;
                        end else begin
                            rate_cnt_d = rate_cnt_q - RATE_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            rate_cnt_q   <= '0;
            gate_q       <= 1'b0;
            stage_q      <= 3'd0;
            env_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            rate_cnt_q   <= rate_cnt_d;
            gate_q       <= bus.gate;
            stage_q      <= state_d;
            env_active_q <= (state_d != S_IDLE);
        end
    end

    // The level register drives vol directly, so vol always equals the level.
    assign bus.vol        = level_q;
    assign bus.stage      = stage_q;
    assign bus.env_active = env_active_q;

endmodule
